// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Requester index width; never narrower than one bit
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a beat count of 0..max_burst
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after ptr, ptr itself lowest priority
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               hit,
  output logic [ID_W-1:0]    idx
);

  // Wrapped segment (0..ptr) first, then the segment after ptr overrides it; lowest index wins in each
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) <= ptr)) begin
        hit = 1'b1;
        idx = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (ID_W'(i) > ptr)) begin
        hit = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: packet-granular round-robin sharing of one FIFO write port; FIFO_ARB_BURST_LIMIT_EN caps beats per grant at MAX_BURST
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter int  MAX_BURST  = 4,
  localparam int ID_W       = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_grant_id, r_last_ptr, w_pick_idx;
  logic                  w_pick_hit, w_load, w_release, w_burst_done;
  logic                  w_own_valid, w_own_last;
  logic [DATA_WIDTH-1:0] w_own_data;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fifo_rr_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("fifo_rr_arbiter: MAX_BURST must be 1..255");
  end

  // One picker serves both the IDLE grant and the release-time re-pick; last_ptr equals the owner while granted
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (r_last_ptr),
    .hit (w_pick_hit),
    .idx (w_pick_idx)
  );

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int CNT_W = cnt_w(MAX_BURST);
  logic [CNT_W-1:0] r_beat_cnt;
  assign w_burst_done = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  // Beats transferred under the current grant; restarts on every new grant or release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_beat_cnt <= '0;
    else if (w_load || w_release) r_beat_cnt <= '0;
    else if (fifo_wr_en) r_beat_cnt <= r_beat_cnt + 1'b1;
  end
`else
  assign w_burst_done = 1'b0;
`endif

  // Mux the owner's valid, last and data out of the requester vectors
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == r_grant_id) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and handshake; the write side sees full in the same cycle so it never writes while full
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (r_state == IDLE) begin
      w_load      = w_pick_hit;
      w_state_nxt = w_pick_hit ? GRANT : IDLE;
    end else begin
      req_ready    = fifo_wr_full ? '0 : (NUM_REQ'(1) << r_grant_id);
      fifo_wr_en   = w_own_valid & ~fifo_wr_full;
      fifo_wr_data = w_own_data;
      w_release    = fifo_wr_en & (w_own_last | w_burst_done);
      w_load       = w_release & w_pick_hit;
      w_state_nxt  = (w_release && !w_pick_hit) ? IDLE : GRANT;
    end
  end

  // State, owner and round-robin pointer; the pointer reset value makes requester 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_last_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_grant_id <= w_pick_idx;
        r_last_ptr <= w_pick_idx;
      end
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == GRANT);

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write interface among `NUM_REQ` requesters. Each requester presents a valid/ready beat stream delimited by `req_last`. The arbiter grants one requester at a time and holds the grant for a whole packet, or up to a burst limit when that feature is compiled in. Beats pass straight through to `fifo_wr_en`/`fifo_wr_data`, with backpressure from `fifo_wr_full`. The block sits directly in front of the FIFO write side.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: beat width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: beats per grant before forced rotation, 1..255; used only with `FIFO_ARB_BURST_LIMIT_EN`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_last`  in  NUM_REQ  per-requester final beat of packet.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester beat accepted.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_data`  out  DATA_WIDTH  to FIFO `wr_data`.
- `fifo_wr_full`  in  1  from FIFO `wr_full`.
- `grant_id`  out  ID_W  current owner; ID_W = max(1, clog2(NUM_REQ)).
- `busy`  out  1  high while in GRANT.

## Operation
- States: IDLE and GRANT. Registers: `state`, `grant_id`, `last_ptr` (ID_W), `beat_cnt` (clog2(MAX_BURST+1)).
- Pick: combinational round-robin over `req_valid`. Search starts at `last_ptr`+1 mod NUM_REQ and wraps; `last_ptr` itself has lowest priority.
- IDLE: if any `req_valid` is high, register the winner into `grant_id` and `last_ptr`, set `beat_cnt`=0, and go to GRANT. Otherwise stay in IDLE.
- GRANT, beat handshake:
  - `req_ready[grant_id]` = !`fifo_wr_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en` = `req_valid[grant_id]` & !`fifo_wr_full`.
  - `fifo_wr_data` = `req_data` slice of `grant_id`.
  - A beat transfers when `fifo_wr_en`=1; each transfer increments `beat_cnt`.
- Release occurs on a transferred beat that has `req_last`=1, or (with the macro) on the transfer that brings `beat_cnt`+1 to MAX_BURST.
- On release:
  - Re-pick in the same cycle, excluding nothing, with `last_ptr` = the current owner.
  - On a hit, load the new `grant_id` and stay in GRANT with zero bubble. Otherwise go to IDLE.
  - `beat_cnt` clears in both cases.
- Owner drops `req_valid` mid-packet: the grant is held, no writes occur, and no timeout applies.
- `fifo_wr_full` high: no transfer, no counting, grant held.
- Outside GRANT, all `req_ready`, `fifo_wr_en` and `fifo_wr_data` are 0.

## Timing
- Reset values: `state`=IDLE, `grant_id`=0, `last_ptr`=NUM_REQ-1 (so the first grant favours requester 0), `beat_cnt`=0, `busy`=0. `req_ready`, `fifo_wr_en` and `fifo_wr_data` are all 0.
- Latency: `req_valid` first seen in IDLE at cycle N → grant registered at edge N+1 → first beat can transfer in cycle N+1.
- Back-to-back packets: the cycle after a release beat can carry the new owner's first beat.
- Handshake outputs are combinational from registered state and `fifo_wr_full`. `fifo_wr_full` is sampled in the same cycle as `wr_en`, so the FIFO never sees a write while full.
- Reset asserted mid-packet: outputs drop to reset values asynchronously. The partial packet is abandoned; the FIFO is responsible for its own contents.

## Configuration
- Macro: `FIFO_ARB_BURST_LIMIT_EN`.
- Defined: the grant is forcibly released after MAX_BURST transferred beats even without `req_last`. The requester resumes the rest of its packet at its next grant.
- Undefined: the grant is held until a `req_last` beat. `beat_cnt` and `MAX_BURST` are unused, and `beat_cnt` is not synthesized.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, GRANT};
  - ID width function max(1, clog2(n));
  - burst-counter width function.
- Sub-module `rr_pick`: purely combinational. Inputs `req`[NUM_REQ] and `ptr`[ID_W]; outputs `hit` and `idx`. It is instantiated once and shared by the IDLE and release paths.

## Test plan
- Requester 1 sends 3 beats 0xA1,0xA2,0xA3 (last on the third) with the FIFO empty → grant at cycle +1; `fifo_wr_en` high for 3 consecutive cycles with that data; IDLE afterwards, `last_ptr`=1.
- Requesters 0 and 2 both hold 2-beat packets → order is 0 then 2, zero-bubble handover, 4 consecutive writes.
- `fifo_wr_full` is forced high for 5 cycles mid-packet → `req_ready` and `fifo_wr_en` stay 0 and the grant is held; the transfer resumes on the cycle full drops, with no lost or duplicated beats.
- With the macro, MAX_BURST=4: requester 3 sends a 6-beat packet while requester 0 is waiting → 4 beats, then requester 0's packet, then requester 3's remaining 2 beats.
- Pointer wrap, NUM_REQ=4: `last_ptr`=3 with requests from 0 and 3 → requester 0 granted first.
- `rst_n` pulsed low in the 2nd beat of a packet → `busy`, `req_ready` and `fifo_wr_en` go 0 immediately; after release, the first grant goes to requester 0.
